fb_step_sequencer: RTL
======================

// Module: fb_step_sequencer
// PURPOSE
//  Sequencer/configurator for the loop feedback step generator. Converts the modulation
//  boundary pulse into the paired accumulate trigger (o_trig) and output trigger (o_trig_dly)
//  after a programmable settle delay.
//  Double-buffers gain / mode / constant-step configuration and commits it only at a loop-safe
//  point, so step-generator settings never change between a trig and its trig_dly.
// PARAMETERS
//  CNT_W        16  width of settle counter and i_settle
//  DLY_GAP      2   cycles from o_trig to o_trig_dly (legal 1..15)
//  DEFAULT_GAIN 5   reset value of o_gain_sel and of the shadow gain register
// PORTS
//  i_clk         in   1      system clock (single clock domain)
//  i_rst         in   1      reset, synchronous, active-high
//  i_en          in   1      master sequencing enable
//  i_mod_sync    in   1      1-cycle pulse at each modulation half-period boundary
//  i_settle      in   CNT_W  settle cycles from sync to trig; sampled on the accepted sync
//  i_cfg_wr      in   1      1-cycle strobe: stage i_gain_sel/i_fb_ON/i_const_step
//  i_gain_sel    in   32     staged gain shift select
//  i_fb_ON       in   32     staged feedback mode ([1:0]: 0 off, 1 integrate, 2 const)
//  i_const_step  in   32     staged constant step (signed)
//  i_clr_ovr     in   1      clears o_overrun
//  o_trig        out  1      accumulate trigger, 1-cycle pulse
//  o_trig_dly    out  1      output/gain trigger, 1-cycle pulse
//  o_gain_sel    out  32     active gain select to step generator
//  o_fb_ON       out  32     active feedback mode to step generator
//  o_const_step  out  32     active constant step (signed)
//  o_cfg_pend    out  1      staged config not yet committed
//  o_overrun     out  1      sticky: sync arrived while a sequence was in flight
//  o_cycle_cnt   out  32     number of completed trig/trig_dly pairs, wraps at 2^32
// BEHAVIOUR
//  Reset (i_rst=1 at a clock edge), all registered:
//   - state IDLE; o_trig=0, o_trig_dly=0.
//   - o_gain_sel=shadow gain=DEFAULT_GAIN.
//   - o_fb_ON, o_const_step, o_cfg_pend, o_overrun, o_cycle_cnt = 0; shadow mode/step = 0.
//   - Reset mid-sequence aborts with no trailing pulse.
//  FSM (Moore, registered outputs): IDLE -> WAIT -> TRIG -> GAP -> DLY -> APPLY -> IDLE.
//  IDLE:
//   - i_mod_sync & i_en: load settle counter with i_settle, go to WAIT.
//  WAIT:
//   - Counter at 0: go to TRIG; otherwise decrement.
//   - Timing: sync in cycle T gives o_trig=1 in cycle T+2+i_settle.
//  TRIG:
//   - o_trig=1 for exactly 1 cycle.
//   - Goes to GAP, or straight to DLY when DLY_GAP=1.
//  GAP: waits until o_trig_dly lands exactly DLY_GAP cycles after o_trig.
//  DLY:
//   - o_trig_dly=1 for exactly 1 cycle.
//   - o_cycle_cnt += 1 (wraps).
//  APPLY:
//   - If o_cfg_pend: copy shadow to active outputs and clear o_cfg_pend.
//   - Always returns to IDLE.
//  Pairing rules:
//   - i_en falling in WAIT aborts to IDLE; no o_trig is issued.
//   - Once o_trig has fired, o_trig_dly always follows, whatever i_en does.
//  Overrun:
//   - i_mod_sync while state != IDLE is ignored and sets o_overrun.
//   - An accepted sync in IDLE does not set it.
//   - i_clr_ovr clears o_overrun; a set in the same cycle wins.
//  Config:
//   - i_cfg_wr captures all three inputs into the shadow and sets o_cfg_pend next cycle.
//   - If i_en=0 and state=IDLE, the commit happens in the following cycle
//     (active outputs updated 2 cycles after the strobe).
//   - i_cfg_wr during APPLY: the old shadow is committed, the new value is captured, and
//     o_cfg_pend stays 1 until the next APPLY.
//   - Repeated writes before a commit: last write wins.
//   - Active outputs never change in TRIG, GAP or DLY.
//  Widths: only o_cycle_cnt arithmetic is modular; config values pass through bit-exact.
// STRUCTURE
//  - Package fb_seq_pkg: typedef enum logic [2:0] seq_state_t {IDLE, WAIT, TRIG, GAP, DLY, APPLY};
//    fb_cfg_t struct {gain_sel, fb_ON, const_step}; DEFAULT_GAIN constant.
//  - Sub-module fb_cfg_shadow: shadow + active fb_cfg_t bank with wr/commit/pend.
//  - Top level: FSM, settle and gap counters, overrun flag, cycle counter.
// TESTING
//  1. Reset check: o_gain_sel=5; o_fb_ON, o_const_step, o_trig, o_trig_dly, o_cycle_cnt all 0.
//  2. i_en=1, i_settle=3, sync at T -> o_trig at T+5, o_trig_dly at T+7, o_cycle_cnt=1.
//     Repeat with i_settle=0 -> o_trig at T+2.
//  3. Mid-sequence write: cfg_wr{gain=8, fb_ON=1, step=-100} at T+3 of scenario 2
//     -> outputs unchanged through T+7, commit at T+8, o_cfg_pend 1 -> 0.
//  4. Overrun: second sync at T+4 -> ignored, o_overrun=1 and stays high.
//     i_clr_ovr -> 0. Simultaneous set and clear -> 1.
//  5. Enable edges: i_en dropped in WAIT -> no o_trig.
//     i_en dropped in the o_trig cycle -> o_trig_dly still 2 cycles later.
//  6. i_en=0, cfg_wr{fb_ON=2, step=0x1234} -> active outputs update 2 cycles later.
//     Then i_rst mid-GAP -> no o_trig_dly, all reset values restored.

Source files
------------

// File: rtl/fb_seq_pkg.sv
// Shared types and constants for the loop feedback step sequencer.
package fb_seq_pkg;

  // Reset value of the active and shadow gain select.
  localparam logic [31:0] DEFAULT_GAIN = 32'd5;

  // Sequencer states, in the order they are visited.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    TRIG  = 3'd2,
    GAP   = 3'd3,
    DLY   = 3'd4,
    APPLY = 3'd5
  } seq_state_t;

  // One complete step-generator configuration.
  typedef struct packed {
    logic        [31:0] gain_sel;
    logic        [31:0] fb_ON;
    logic signed [31:0] const_step;
  } fb_cfg_t;

  // Configuration loaded at reset: given gain, feedback off, zero step.
  function automatic fb_cfg_t cfg_reset(input logic [31:0] gain);
    fb_cfg_t c;
    c.gain_sel   = gain;
    c.fb_ON      = '0;
    c.const_step = '0;
    return c;
  endfunction

endpackage

// File: rtl/fb_cfg_shadow.sv
// Double-buffered configuration bank: writes land in a shadow copy and only
// reach the active outputs when the sequencer raises commit at a safe point.
module fb_cfg_shadow
  import fb_seq_pkg::*;
#(
  parameter logic [31:0] RST_GAIN = DEFAULT_GAIN
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    wr,
  input  fb_cfg_t wr_cfg,
  input  logic    commit,
  output fb_cfg_t active,
  output logic    pend
);

  fb_cfg_t shadow;

  // Shadow capture: the most recent write always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= cfg_reset(RST_GAIN);
    end else if (wr) begin
      shadow <= wr_cfg;
    end
  end

  // Active bank takes the shadow value present before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= cfg_reset(RST_GAIN);
    end else if (commit) begin
      active <= shadow;
    end
  end

  // Pending flag: a write sets it (even alongside a commit), a commit alone clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (wr) begin
      pend <= 1'b1;
    end else if (commit) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/fb_step_sequencer.sv
// Turns each modulation boundary pulse into an accumulate trigger followed by
// an output trigger a fixed gap later, and commits staged configuration only
// once the pair has completed.
module fb_step_sequencer #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DLY_GAP      = 2,
  parameter logic [31:0] DEFAULT_GAIN = fb_seq_pkg::DEFAULT_GAIN
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_mod_sync,
  input  logic [CNT_W-1:0]    i_settle,
  input  logic                i_cfg_wr,
  input  logic [31:0]         i_gain_sel,
  input  logic [31:0]         i_fb_ON,
  input  logic signed [31:0]  i_const_step,
  input  logic                i_clr_ovr,
  output logic                o_trig,
  output logic                o_trig_dly,
  output logic [31:0]         o_gain_sel,
  output logic [31:0]         o_fb_ON,
  output logic signed [31:0]  o_const_step,
  output logic                o_cfg_pend,
  output logic                o_overrun,
  output logic [31:0]         o_cycle_cnt
);

  import fb_seq_pkg::*;

  // GAP is entered one cycle after TRIG and left one cycle before DLY, so it
  // has to burn DLY_GAP-2 extra cycles before moving on.
  localparam logic [3:0] GAP_LOAD = (DLY_GAP > 1) ? 4'(DLY_GAP - 2) : 4'd0;

  seq_state_t       state;
  seq_state_t       next_state;
  logic [CNT_W-1:0] settle_cnt;
  logic [3:0]       gap_cnt;
  logic             trig;
  logic             trig_dly;
  logic             overrun;
  logic [31:0]      cycle_cnt;
  logic             commit;
  logic             cfg_pend;
  fb_cfg_t          wr_cfg;
  fb_cfg_t          active_cfg;

  // Next-state logic; enable only matters before the accumulate trigger fires.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (i_mod_sync && i_en) next_state = WAIT;
      end
      WAIT: begin
        if (!i_en)                next_state = IDLE;
        else if (settle_cnt == '0) next_state = TRIG;
      end
      TRIG: begin
        next_state = (DLY_GAP == 1) ? DLY : GAP;
      end
      GAP: begin
        if (gap_cnt == 4'd0) next_state = DLY;
      end
      DLY: begin
        next_state = APPLY;
      end
      APPLY: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register with trigger pulses registered from the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      trig     <= 1'b0;
      trig_dly <= 1'b0;
    end else begin
      state    <= next_state;
      trig     <= (next_state == TRIG);
      trig_dly <= (next_state == DLY);
    end
  end

  // Settle counter: loaded on the accepted sync, counts down while waiting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      settle_cnt <= '0;
    end else if (state == IDLE && next_state == WAIT) begin
      settle_cnt <= i_settle;
    end else if (state == WAIT && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - CNT_W'(1);
    end
  end

  // Gap counter: loaded in TRIG, counts down in GAP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gap_cnt <= 4'd0;
    end else if (state == TRIG) begin
      gap_cnt <= GAP_LOAD;
    end else if (state == GAP && gap_cnt != 4'd0) begin
      gap_cnt <= gap_cnt - 4'd1;
    end
  end

  // Completed-pair counter, advanced together with the output trigger.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_cnt <= 32'd0;
    end else if (next_state == DLY) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // Sticky overrun: a sync that cannot be accepted sets it, and beats a clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overrun <= 1'b0;
    end else if (i_mod_sync && state != IDLE) begin
      overrun <= 1'b1;
    end else if (i_clr_ovr) begin
      overrun <= 1'b0;
    end
  end

  // Commit on entry to APPLY so the new values never appear between the
  // triggers, or right away when the sequencer is idle and disabled.
  assign commit = cfg_pend && ((state == IDLE && !i_en) || next_state == APPLY);

  assign wr_cfg = '{gain_sel: i_gain_sel, fb_ON: i_fb_ON, const_step: i_const_step};

  fb_cfg_shadow #(
    .RST_GAIN (DEFAULT_GAIN)
  ) u_cfg (
    .clk    (i_clk),
    .rst    (i_rst),
    .wr     (i_cfg_wr),
    .wr_cfg (wr_cfg),
    .commit (commit),
    .active (active_cfg),
    .pend   (cfg_pend)
  );

  assign o_trig       = trig;
  assign o_trig_dly   = trig_dly;
  assign o_gain_sel   = active_cfg.gain_sel;
  assign o_fb_ON      = active_cfg.fb_ON;
  assign o_const_step = active_cfg.const_step;
  assign o_cfg_pend   = cfg_pend;
  assign o_overrun    = overrun;
  assign o_cycle_cnt  = cycle_cnt;

endmodule
